// File: rtl/mic_rx_stereo.sv
// mic_rx_stereo: stereo ADC deserialiser (left-justified or I2S) into an N-bit frame-pair FIFO with valid/ready output.
// Optional MIC_RX_OVF_COUNT_EN adds ovf_count, a saturating count of dropped frames.
module mic_rx_stereo #(
  parameter int N          = 16,
  parameter int I2S_DELAY  = 0,
  parameter int LEFT_HIGH  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         bclk,
  input  logic         reset,
  input  logic         adclrc,
  input  logic         adcdat,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] out_left,
  output logic [N-1:0] out_right,
  output logic         overflow,
  output logic         frame_err
`ifdef MIC_RX_OVF_COUNT_EN
  ,
  output logic [7:0]   ovf_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(N);
  localparam logic [BW-1:0] LAST = BW'(N - 1);
  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, HOLD} state_t;
  state_t state;
  logic adclrc_q, started, is_right;
  logic [BW-1:0] bit_idx;
  logic [N-1:0] word, left_hold, word_nxt;
  logic [2*N-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic left_edge, right_edge, any_edge, short_slot, started_eff, start;
  logic push, full, pop, wr_ok, drop;
  always_comb begin
    left_edge   = LEFT_HIGH != 0 ? (adclrc & ~adclrc_q) : (~adclrc & adclrc_q);
    right_edge  = LEFT_HIGH != 0 ? (~adclrc & adclrc_q) : (adclrc & ~adclrc_q);
    any_edge    = left_edge | right_edge;
    short_slot  = any_edge & (state == DELAY || state == SHIFT);
    started_eff = started & ~short_slot;
    // right slots are only captured once a left word of the same frame is held
    start       = left_edge | (right_edge & started_eff);
    word_nxt    = {word[N-2:0], adcdat};
    push        = state == SHIFT && !any_edge && bit_idx == LAST && is_right && started;
    full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    out_valid   = wptr != rptr;
    pop         = out_valid & out_ready;
    wr_ok       = push & (~full | pop);
    drop        = push & full & ~pop;
    out_left    = mem[rptr[AW-1:0]][2*N-1:N];
    out_right   = mem[rptr[AW-1:0]][N-1:0];
  end
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      adclrc_q  <= 1'b0;
      started   <= 1'b0;
      is_right  <= 1'b0;
      bit_idx   <= '0;
      word      <= '0;
      left_hold <= '0;
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
`ifdef MIC_RX_OVF_COUNT_EN
      ovf_count <= 8'd0;
`endif
    end else begin
      adclrc_q  <= adclrc;
      frame_err <= short_slot;
      if (any_edge) begin
        started  <= started_eff;
        is_right <= right_edge;
        if (!start) state <= IDLE;
        else if (I2S_DELAY != 0) state <= DELAY;
        else begin
          state   <= SHIFT;
          word    <= word_nxt;
          bit_idx <= BW'(1);
        end
      end else if (state == DELAY) begin
        // the edge cycle carried the I2S delay bit; this cycle carries the MSB
        state   <= SHIFT;
        word    <= word_nxt;
        bit_idx <= BW'(1);
      end else if (state == SHIFT) begin
        word    <= word_nxt;
        bit_idx <= bit_idx + 1'b1;
        if (bit_idx == LAST) begin
          state <= HOLD;
          if (!is_right) begin
            left_hold <= word_nxt;
            started   <= 1'b1;
          end else started <= 1'b0;
        end
      end
      if (wr_ok) begin
        mem[wptr[AW-1:0]] <= {left_hold, word_nxt};
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (drop) overflow <= 1'b1;
`ifdef MIC_RX_OVF_COUNT_EN
      if (drop && ovf_count != 8'hff) ovf_count <= ovf_count + 8'd1;
`endif
    end
  end
endmodule
